// File: rtl/sd_spi_read_if.sv
// rtl/sd_spi_read_if.sv - SD SPI single-block reader bus: card SPI pins plus user read handshake
//
// Signals:
//   sd_spi_miso  card -> reader serial data
//   sd_spi_clk   reader -> card SPI clock, idles low
//   sd_spi_cs    reader -> card chip select, active low
//   sd_spi_mosi  reader -> card serial data, idles high
//   rd_start_en  user -> reader read request (rising edge)
//   rd_sec_addr  user -> reader 32-bit sector address
//   rd_busy      reader -> user, read in progress
//   rd_val_en    reader -> user, one-cycle word strobe
//   rd_val_data  reader -> user, 16-bit sector word
//   rd_err       reader -> user, sticky error of the last read
// Modports: master = the reader, slave = card/user environment.
interface sd_spi_read_if;
    logic        sd_spi_miso;
    logic        sd_spi_clk;
    logic        sd_spi_cs;
    logic        sd_spi_mosi;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic        rd_err;

    modport master (
        input  sd_spi_miso, rd_start_en, rd_sec_addr,
        output sd_spi_clk, sd_spi_cs, sd_spi_mosi, rd_busy, rd_val_en, rd_val_data, rd_err
    );

    modport slave (
        output sd_spi_miso, rd_start_en, rd_sec_addr,
        input  sd_spi_clk, sd_spi_cs, sd_spi_mosi, rd_busy, rd_val_en, rd_val_data, rd_err
    );
endinterface

// File: rtl/sd_spi_read.sv
// rtl/sd_spi_read.sv - SD card single-block (CMD17) reader over SPI, 512 bytes out as 256 words
//
// Ports:
//   clk_sd  system clock, all logic on the rising edge
//   reset   synchronous active-high reset
//   bus     sd_spi_read_if.master: SPI pins to the card and the user read handshake
// Each SPI bit spans two clk_sd cycles: SCLK low (MOSI changes on entry), then SCLK high
// (MISO sampled on the edge that raises SCLK).
module sd_spi_read #(
    parameter logic [7:0] CMD_CRC       = 8'hFF,
    parameter int         RESP_TIMEOUT  = 8,
    parameter int         TOKEN_TIMEOUT = 1024
) (
    input  logic          clk_sd,
    input  logic          reset,
    sd_spi_read_if.master bus
);

    localparam int TMO_W = $clog2(TOKEN_TIMEOUT * 8 + 1);
    localparam logic [TMO_W-1:0] R1_LAST  = TMO_W'(RESP_TIMEOUT * 8 - 1);
    localparam logic [TMO_W-1:0] TOK_LAST = TMO_W'(TOKEN_TIMEOUT * 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_R1,
        S_WAIT_TOK,
        S_DATA,
        S_CRC,
        S_TAIL
    } state_t;

    state_t           state;
    logic             start_d1;
    logic             start_d2;
    logic [46:0]      cmd_sh;     // frame bits still to send; bit 47 goes straight to MOSI
    logic [14:0]      rx_sh;      // received history; current MISO bit completes the byte/word
    logic [12:0]      bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             r1_cap;     // R1 start bit seen, collecting the remaining 7 bits

    logic        start_edge;
    logic [47:0] cmd_frame;
    logic [7:0]  rx_byte;
    logic [15:0] rx_word;

    assign start_edge = start_d1 & ~start_d2;
    assign cmd_frame  = {8'h51, bus.rd_sec_addr, CMD_CRC};
    assign rx_byte    = {rx_sh[6:0], bus.sd_spi_miso};
    assign rx_word    = {rx_sh, bus.sd_spi_miso};

    always_ff @(posedge clk_sd) begin
        if (reset) begin
            state           <= S_IDLE;
            start_d1        <= 1'b0;
            start_d2        <= 1'b0;
            cmd_sh          <= '0;
            rx_sh           <= '0;
            bit_cnt         <= '0;
            tmo_cnt         <= '0;
            r1_cap          <= 1'b0;
            bus.sd_spi_clk  <= 1'b0;
            bus.sd_spi_cs   <= 1'b1;
            bus.sd_spi_mosi <= 1'b1;
            bus.rd_busy     <= 1'b0;
            bus.rd_val_en   <= 1'b0;
            bus.rd_val_data <= '0;
            bus.rd_err      <= 1'b0;
        end else begin
            start_d1      <= bus.rd_start_en;
            start_d2      <= start_d1;
            bus.rd_val_en <= 1'b0;

            case (state)
                S_IDLE: begin
                    bus.sd_spi_clk  <= 1'b0;
                    bus.sd_spi_cs   <= 1'b1;
                    bus.sd_spi_mosi <= 1'b1;
                    if (start_edge) begin
                        // CS drops now; SCLK first rises on the following cycle
                        cmd_sh          <= cmd_frame[46:0];
                        bus.sd_spi_mosi <= cmd_frame[47];
                        bus.sd_spi_cs   <= 1'b0;
                        bus.rd_busy     <= 1'b1;
                        bus.rd_err      <= 1'b0;
                        bit_cnt         <= '0;
                        state           <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (!bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b1;
                    end else begin
                        bus.sd_spi_clk <= 1'b0;
                        if (bit_cnt == 13'd47) begin
                            bus.sd_spi_mosi <= 1'b1;
                            bit_cnt         <= '0;
                            tmo_cnt         <= '0;
                            rx_sh           <= '0;
                            r1_cap          <= 1'b0;
                            state           <= S_WAIT_R1;
                        end else begin
                            bus.sd_spi_mosi <= cmd_sh[46];
                            cmd_sh          <= {cmd_sh[45:0], 1'b1};
                            bit_cnt         <= bit_cnt + 13'd1;
                        end
                    end
                end

                S_WAIT_R1: begin
                    if (!bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b1;
                        if (r1_cap) begin
                            rx_sh <= {rx_sh[13:0], bus.sd_spi_miso};
                            if (bit_cnt == 13'd7) begin
                                bit_cnt <= '0;
                                tmo_cnt <= '0;
                                rx_sh   <= '0;
                                if (rx_byte == 8'h00) begin
                                    state <= S_WAIT_TOK;
                                end else begin
                                    bus.rd_err <= 1'b1;
                                    state      <= S_TAIL;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 13'd1;
                            end
                        end else if (!bus.sd_spi_miso) begin
                            // the start bit itself is R1 bit 7 (always 0)
                            r1_cap  <= 1'b1;
                            rx_sh   <= '0;
                            bit_cnt <= 13'd1;
                        end else if (tmo_cnt == R1_LAST) begin
                            bus.rd_err <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= S_TAIL;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end else begin
                        bus.sd_spi_clk <= 1'b0;
                    end
                end

                S_WAIT_TOK: begin
                    if (!bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b1;
                        rx_sh          <= {rx_sh[13:0], bus.sd_spi_miso};
                        // rx_sh starts at zero so no partial window can look like 0xFE
                        if (rx_byte == 8'hFE) begin
                            rx_sh   <= '0;
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end else if (tmo_cnt == TOK_LAST) begin
                            bus.rd_err <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= S_TAIL;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end else begin
                        bus.sd_spi_clk <= 1'b0;
                    end
                end

                S_DATA: begin
                    if (!bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b1;
                        rx_sh          <= {rx_sh[13:0], bus.sd_spi_miso};
                        if (bit_cnt[3:0] == 4'hF) begin
                            bus.rd_val_data <= rx_word;
                            bus.rd_val_en   <= 1'b1;
                        end
                        if (bit_cnt == 13'd4095) begin
                            bit_cnt <= '0;
                            state   <= S_CRC;
                        end else begin
                            bit_cnt <= bit_cnt + 13'd1;
                        end
                    end else begin
                        bus.sd_spi_clk <= 1'b0;
                    end
                end

                S_CRC: begin
                    if (!bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b1;
                        if (bit_cnt == 13'd15) begin
                            bit_cnt <= '0;
                            state   <= S_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 13'd1;
                        end
                    end else begin
                        bus.sd_spi_clk <= 1'b0;
                    end
                end

                S_TAIL: begin
                    // Entered with SCLK high; CS rises together with that last falling edge,
                    // so all 8 following SCLK pulses happen with the card deselected.
                    bus.sd_spi_mosi <= 1'b1;
                    if (bus.sd_spi_clk) begin
                        bus.sd_spi_clk <= 1'b0;
                        bus.sd_spi_cs  <= 1'b1;
                        if (bit_cnt == 13'd8) begin
                            bus.rd_busy <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= S_IDLE;
                        end
                    end else begin
                        bus.sd_spi_clk <= 1'b1;
                        bit_cnt        <= bit_cnt + 13'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
